// File: rtl/pipe_timer.sv
// Memory-mapped countdown timer for the M-stage bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload expiry with a maskable interrupt request.
module pipe_timer #(
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  state_t      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic        ctrl_wr_d;
  logic        preset_wr_d;

  assign ctrl_wr_d   = we && (addr[3:2] == A_CTRL);
  assign preset_wr_d = we && (addr[3:2] == A_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= RESET_PRESET;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_q) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q    <= preset_q;
          // only an auto-reload pulse can be pending here; it lasts one cycle
          irq_flag_q <= 1'b0;
          state_q    <= S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_q <= S_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= S_INT;
          end
        end
        S_INT: begin
          irq_flag_q <= 1'b1;
          if (mode_q == 2'b01) begin
            state_q <= S_LOAD;
          end else begin
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // bus writes come last so they override the FSM's EN clear and flag set
      if (ctrl_wr_d) begin
        en_q       <= wdata[0];
        mode_q     <= wdata[2:1];
        im_q       <= wdata[3];
        irq_flag_q <= 1'b0;
      end
      if (preset_wr_d) preset_q <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      A_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      A_PRESET: rdata = preset_q;
      A_COUNT:  rdata = count_q;
      A_RSVD:   rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & im_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

endmodule
